mem_subword_ctrl: RTL and testbench

Sequencer between the MEM stage of the 5-cycle pipeline and a word-only data memory port. It accepts one load/store at a time and performs word accesses directly. It performs byte loads as a word read followed by big-endian byte extract with zero or sign extension. It performs byte stores as a read-modify-write: read the word, merge the byte, write the word. The pipeline stalls on `op_ready`/`done`.

---
 rtl/mem_subword_ctrl_if.sv | 30 +++
 rtl/mem_subword_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mem_subword_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_subword_ctrl_if.sv
// Pipeline request/response bus plus the word-only memory port of mem_subword_ctrl.
interface mem_subword_ctrl_if;
    // A request is taken on a rising edge with op_valid && op_ready; the result is valid
    // only in the single done cycle. A memory access completes on an edge with
    // mem_req && mem_ack, and mem_addr/mem_we/mem_wdata hold steady while mem_req=1.
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_kind;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    // slave is the controller; master is the pipeline and memory surrounding it.
    modport slave (
        input  op_valid, op_kind, op_addr, op_wdata, mem_ack, mem_rdata,
        output op_ready, done, rdata, err, mem_req, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output op_valid, op_kind, op_addr, op_wdata, mem_ack, mem_rdata,
        input  op_ready, done, rdata, err, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_subword_ctrl.sv
// Sequences LW/SW/LB/LBU/SB onto a word-only memory: byte loads extract a big-endian
// lane from a word read, byte stores do read-merge-write.
module mem_subword_ctrl #(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_subword_ctrl_if.slave  bus,
    output logic [1:0]         state_o
);
    localparam logic [2:0]  K_LW  = 3'b000;
    localparam logic [2:0]  K_SW  = 3'b001;
    localparam logic [2:0]  K_LB  = 3'b010;
    localparam logic [2:0]  K_LBU = 3'b011;
    localparam logic [2:0]  K_SB  = 3'b100;
    localparam logic [31:0] TO_LAST = TIMEOUT - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  kind_q, kind_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  byte_q, byte_d;
    logic [31:0] mwdata_q, mwdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] wdog_q, wdog_d;
    logic        wdog_hit;
    logic        req_bad;

    // Lane 0 (addr[1:0]=00) is the most significant byte.
    function automatic logic [7:0] lane_get(input logic [31:0] w, input logic [1:0] lane);
        case (lane)
            2'b00:   lane_get = w[31:24];
            2'b01:   lane_get = w[23:16];
            2'b10:   lane_get = w[15:8];
            default: lane_get = w[7:0];
        endcase
    endfunction

    function automatic logic [31:0] lane_put(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [7:0] b);
        lane_put = w;
        case (lane)
            2'b00:   lane_put[31:24] = b;
            2'b01:   lane_put[23:16] = b;
            2'b10:   lane_put[15:8]  = b;
            default: lane_put[7:0]   = b;
        endcase
    endfunction

    function automatic logic [31:0] load_result(input logic [2:0] kind, input logic [31:0] w,
                                                input logic [1:0] lane);
        logic [7:0] b;
        b = lane_get(w, lane);
        case (kind)
            K_LB:    load_result = {{24{b[7]}}, b};
            K_LBU:   load_result = {24'h0, b};
            default: load_result = w;
        endcase
    endfunction

    // Word accesses need natural alignment; byte accesses may use any lane.
    assign req_bad  = (bus.op_kind > K_SB) ||
                      (((bus.op_kind == K_LW) || (bus.op_kind == K_SW)) && (bus.op_addr[1:0] != 2'b00));
    assign wdog_hit = (TIMEOUT != 0) && (wdog_q == TO_LAST);

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        addr_d   = addr_q;
        byte_d   = byte_q;
        mwdata_d = mwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        wdog_d   = wdog_q;
        case (state_q)
            S_IDLE: begin
                if (bus.op_valid) begin
                    kind_d = bus.op_kind;
                    addr_d = bus.op_addr;
                    byte_d = bus.op_wdata[7:0];
                    wdog_d = '0;
                    if (req_bad) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (bus.op_kind == K_SW) begin
                        state_d  = S_WR;
                        mwdata_d = bus.op_wdata;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                if (bus.mem_ack) begin
                    if (kind_q == K_SB) begin
                        state_d  = S_WR;
                        mwdata_d = lane_put(bus.mem_rdata, addr_q[1:0], byte_q);
                        wdog_d   = '0;
                    end else begin
                        state_d = S_RESP;
                        err_d   = 1'b0;
                        rdata_d = load_result(kind_q, bus.mem_rdata, addr_q[1:0]);
                    end
                end else if (wdog_hit) begin
                    // Abandoning the read also cancels any pending SB write.
                    state_d = S_RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
            end
            S_WR: begin
                if (bus.mem_ack) begin
                    state_d = S_RESP;
                    err_d   = 1'b0;
                    rdata_d = '0;
                end else if (wdog_hit) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            kind_q   <= '0;
            addr_q   <= '0;
            byte_q   <= '0;
            mwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            wdog_q   <= '0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            addr_q   <= addr_d;
            byte_q   <= byte_d;
            mwdata_q <= mwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            wdog_q   <= wdog_d;
        end
    end

    // All outputs decode from registers, so reset clears mem_req without a clock edge.
    assign bus.op_ready  = (state_q == S_IDLE);
    assign bus.done      = (state_q == S_RESP);
    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q;
    assign bus.mem_req   = (state_q == S_RD) || (state_q == S_WR);
    assign bus.mem_we    = (state_q == S_WR);
    assign bus.mem_addr  = {addr_q[31:2], 2'b00};
    assign bus.mem_wdata = mwdata_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_mem_subword_ctrl.sv
// Self-checking bench for mem_subword_ctrl: directed vector table, hand sequences for
// wait states, watchdog and reset, then random ops against a lane-arithmetic model.
module tb_mem_subword_ctrl;
    localparam int unsigned TO = 4;

    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;
    int         total;
    int         bad;

    mem_subword_ctrl_if bus ();

    mem_subword_ctrl #(.TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not end within budget");
        $fatal(1, "time limit");
    end

    // ---------------- memory, responder and monitors ----------------
    logic [31:0] mem     [logic [29:0]];
    logic [31:0] ref_mem [logic [29:0]];
    int          dly_q[$];
    logic [64:0] acc_q[$];
    logic [64:0] exp_q[$];
    int          req_cycles;
    int          stab_bad;
    int          wait_cnt;
    int          cur_dly;
    bit          new_acc;
    logic        prev_req;
    logic        prev_we;
    logic [31:0] prev_addr;
    logic [31:0] prev_wd;

    function automatic logic [31:0] init_word(input logic [29:0] w);
        return {w[15:0], ~w[15:0]} ^ 32'h5a3c_96e1;
    endfunction

    function automatic logic [31:0] mem_get(input logic [29:0] w);
        if (mem.exists(w)) return mem[w];
        return init_word(w);
    endfunction

    function automatic logic [31:0] ref_get(input logic [29:0] w);
        if (ref_mem.exists(w)) return ref_mem[w];
        return init_word(w);
    endfunction

    // Each access waits the number of cycles popped from dly_q before acking.
    always @(negedge clk) begin
        if (!bus.mem_req) begin
            bus.mem_ack   = 1'($urandom_range(0, 1));
            bus.mem_rdata = $urandom;
            wait_cnt      = 0;
            new_acc       = 1'b1;
        end else begin
            if (bus.mem_ack) begin
                new_acc  = 1'b1;
                wait_cnt = 0;
            end
            if (new_acc) begin
                cur_dly = 0;
                if (dly_q.size() != 0) cur_dly = dly_q.pop_front();
                new_acc = 1'b0;
            end
            if (wait_cnt >= cur_dly) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem_get(bus.mem_addr[31:2]);
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = $urandom;
                wait_cnt++;
            end
        end
    end

    always @(posedge clk) begin
        if (bus.mem_req && bus.mem_ack) begin
            if (bus.mem_we) begin
                mem[bus.mem_addr[31:2]] = bus.mem_wdata;
                acc_q.push_back({1'b1, bus.mem_addr, bus.mem_wdata});
            end else begin
                acc_q.push_back({1'b0, bus.mem_addr, 32'h0});
            end
        end
    end

    always @(negedge clk) begin
        if (bus.mem_req) begin
            req_cycles++;
            if (prev_req && (prev_we == bus.mem_we) &&
                ((prev_addr != bus.mem_addr) || (prev_wd != bus.mem_wdata)))
                stab_bad++;
        end
        prev_req  = bus.mem_req;
        prev_we   = bus.mem_we;
        prev_addr = bus.mem_addr;
        prev_wd   = bus.mem_wdata;
    end

    // ---------------- checking and driving ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_log(input string name);
        chk({name, "_nacc"}, acc_q.size(), exp_q.size());
        while ((acc_q.size() != 0) && (exp_q.size() != 0)) begin
            logic [64:0] got;
            logic [64:0] want;
            got  = acc_q.pop_front();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL %s_access: got we=%0b addr=%h data=%h expected we=%0b addr=%h data=%h",
                         name, got[64], got[63:32], got[31:0], want[64], want[63:32], want[31:0]);
            end
        end
        acc_q.delete();
        exp_q.delete();
    endtask

    task automatic run_op(input logic [2:0] k, input logic [31:0] a, input logic [31:0] wd,
                          input bit junk, output logic [31:0] rd, output logic e, output int lat);
        @(negedge clk);
        chk("ready_before_op", 32'(bus.op_ready), 32'd1);
        req_cycles   = 0;
        bus.op_valid = 1'b1;
        bus.op_kind  = k;
        bus.op_addr  = a;
        bus.op_wdata = wd;
        @(posedge clk);
        #1;
        if (junk) begin
            bus.op_kind  = 3'b001;
            bus.op_addr  = 32'h0000_6000;
            bus.op_wdata = $urandom;
        end else begin
            bus.op_valid = 1'b0;
            bus.op_kind  = 3'($urandom_range(0, 7));
            bus.op_addr  = $urandom;
            bus.op_wdata = $urandom;
        end
        lat = 1;
        @(negedge clk);
        while (!bus.done && (lat < 200)) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.done) chk("done_wait_bound", 32'(bus.done), 32'd1);
        rd           = bus.rdata;
        e            = bus.err;
        bus.op_valid = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] memw;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        bit          do_rd;
        bit          do_wr;
        logic [31:0] exp_wr;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    logic [31:0] rd, a, wd, cur, nw, erd;
    logic        e, eerr, chk_rd;
    logic [2:0]  k;
    logic [29:0] w;
    logic [7:0]  byt;
    int          lat, elat, d1, d2, sh, n;

    initial begin
        total        = 0;
        bad          = 0;
        req_cycles   = 0;
        stab_bad     = 0;
        rst_n        = 1'b0;
        bus.op_valid = 1'b0;
        bus.op_kind  = 3'b000;
        bus.op_addr  = 32'h0;
        bus.op_wdata = 32'h0;

        //           kind    addr          wdata         mem word      exp rdata     err  lat rd wr write data
        vecs[0]  = '{3'b011, 32'h0000_1001, 32'h0,        32'h1280_5678, 32'h0000_0080, 1'b0, 2, 1, 0, 32'h0};
        vecs[1]  = '{3'b010, 32'h0000_1001, 32'h0,        32'h1280_5678, 32'hFFFF_FF80, 1'b0, 2, 1, 0, 32'h0};
        vecs[2]  = '{3'b000, 32'h0000_1000, 32'h0,        32'h1280_5678, 32'h1280_5678, 1'b0, 2, 1, 0, 32'h0};
        vecs[3]  = '{3'b011, 32'h0000_1000, 32'h0,        32'h1280_5678, 32'h0000_0012, 1'b0, 2, 1, 0, 32'h0};
        vecs[4]  = '{3'b010, 32'h0000_1002, 32'h0,        32'h1280_5678, 32'h0000_0056, 1'b0, 2, 1, 0, 32'h0};
        vecs[5]  = '{3'b011, 32'h0000_1003, 32'h0,        32'h1280_5678, 32'h0000_0078, 1'b0, 2, 1, 0, 32'h0};
        vecs[6]  = '{3'b010, 32'h0000_4002, 32'h0,        32'h0000_F000, 32'hFFFF_FFF0, 1'b0, 2, 1, 0, 32'h0};
        vecs[7]  = '{3'b011, 32'h0000_4002, 32'h0,        32'h0000_F000, 32'h0000_00F0, 1'b0, 2, 1, 0, 32'h0};
        vecs[8]  = '{3'b100, 32'h0000_2003, 32'h0000_00AB, 32'h1122_3344, 32'h0,        1'b0, 3, 1, 1, 32'h1122_33AB};
        vecs[9]  = '{3'b100, 32'h0000_2000, 32'h0000_00AB, 32'h1122_3344, 32'h0,        1'b0, 3, 1, 1, 32'hAB22_3344};
        vecs[10] = '{3'b100, 32'h0000_2001, 32'hFFFF_FFCD, 32'h1122_3344, 32'h0,        1'b0, 3, 1, 1, 32'h11CD_3344};
        vecs[11] = '{3'b100, 32'h0000_2002, 32'h1234_5677, 32'h1122_3344, 32'h0,        1'b0, 3, 1, 1, 32'h1122_7744};
        vecs[12] = '{3'b001, 32'h0000_3000, 32'hDEAD_BEEF, 32'h0,         32'h0,        1'b0, 2, 0, 1, 32'hDEAD_BEEF};
        vecs[13] = '{3'b001, 32'h0000_3002, 32'hDEAD_BEEF, 32'h0,         32'h0,        1'b1, 1, 0, 0, 32'h0};
        vecs[14] = '{3'b111, 32'h0000_3000, 32'h0,        32'h0,         32'h0,        1'b1, 1, 0, 0, 32'h0};
        vecs[15] = '{3'b000, 32'h0000_1001, 32'h0,        32'h1280_5678, 32'h0,        1'b1, 1, 0, 0, 32'h0};
        vecs[16] = '{3'b101, 32'h0000_1000, 32'h0,        32'h1280_5678, 32'h0,        1'b1, 1, 0, 0, 32'h0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_op_ready",  32'(bus.op_ready), 32'd1);
        chk("rst_done",      32'(bus.done),     32'd0);
        chk("rst_err",       32'(bus.err),      32'd0);
        chk("rst_mem_req",   32'(bus.mem_req),  32'd0);
        chk("rst_mem_we",    32'(bus.mem_we),   32'd0);
        chk("rst_rdata",     bus.rdata,         32'h0);
        chk("rst_mem_addr",  bus.mem_addr,      32'h0);
        chk("rst_mem_wdata", bus.mem_wdata,     32'h0);
        chk("rst_state",     32'(state_dbg),    32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            a = vecs[i].addr;
            mem[a[31:2]] = vecs[i].memw;
            if (vecs[i].do_rd) exp_q.push_back({1'b0, a[31:2], 2'b00, 32'h0});
            if (vecs[i].do_wr) exp_q.push_back({1'b1, a[31:2], 2'b00, vecs[i].exp_wr});
            run_op(vecs[i].kind, vecs[i].addr, vecs[i].wdata, 1'b0, rd, e, lat);
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
            if (!vecs[i].exp_err) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_req_cycles", i), req_cycles, 32'(vecs[i].do_rd) + 32'(vecs[i].do_wr));
            check_log($sformatf("vec%0d", i));
        end

        // LW with three wait states while a second request is held on op_valid.
        a = 32'h0000_5000;
        mem[a[31:2]] = 32'hCAFE_F00D;
        dly_q.push_back(3);
        exp_q.push_back({1'b0, 32'h0000_5000, 32'h0});
        run_op(3'b000, a, 32'h0, 1'b1, rd, e, lat);
        chk("wait_rdata", rd, 32'hCAFE_F00D);
        chk("wait_err", 32'(e), 32'd0);
        chk("wait_latency", lat, 32'd5);
        chk("wait_req_cycles", req_cycles, 32'd4);
        repeat (2) @(negedge clk);
        chk("wait_ready_after", 32'(bus.op_ready), 32'd1);
        check_log("wait_ignore_second");

        // SB whose read is never acked: watchdog gives up, no write is issued.
        dly_q.push_back(1000);
        run_op(3'b100, 32'h0000_7002, 32'h0000_0055, 1'b0, rd, e, lat);
        chk("tmo_err", 32'(e), 32'd1);
        chk("tmo_rdata", rd, 32'h0);
        chk("tmo_latency", lat, 32'd5);
        chk("tmo_req_cycles", req_cycles, 32'd4);
        check_log("tmo");
        dly_q.delete();

        // Reset asserted while the SB write is pending.
        a = 32'h0000_7001;
        mem[a[31:2]] = 32'h9988_7766;
        dly_q.push_back(0);
        dly_q.push_back(1000);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op_kind  = 3'b100;
        bus.op_addr  = a;
        bus.op_wdata = 32'h0000_00EE;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.mem_we && (n < 20)) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_reached_wr", 32'(bus.mem_we), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_req",   32'(bus.mem_req),  32'd0);
        chk("rst_mid_mem_we",    32'(bus.mem_we),   32'd0);
        chk("rst_mid_op_ready",  32'(bus.op_ready), 32'd1);
        chk("rst_mid_done",      32'(bus.done),     32'd0);
        chk("rst_mid_err",       32'(bus.err),      32'd0);
        chk("rst_mid_rdata",     bus.rdata,         32'h0);
        chk("rst_mid_mem_addr",  bus.mem_addr,      32'h0);
        chk("rst_mid_mem_wdata", bus.mem_wdata,     32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dly_q.delete();
        chk("rst_mid_mem_kept", mem_get(a[31:2]), 32'h9988_7766);
        exp_q.push_back({1'b0, 32'h0000_7000, 32'h0});
        check_log("rst_mid");
        exp_q.push_back({1'b0, 32'h0000_7000, 32'h0});
        run_op(3'b000, 32'h0000_7000, 32'h0, 1'b0, rd, e, lat);
        chk("post_rst_rdata", rd, 32'h9988_7766);
        chk("post_rst_latency", lat, 32'd2);
        check_log("post_rst");

        // Random ops against the reference model over a small address window.
        for (int i = 0; i < 250; i++) begin
            k  = 3'($urandom_range(0, 7));
            a  = 32'h0000_8000 + $urandom_range(0, 63);
            wd = $urandom;
            d1 = ($urandom_range(0, 7) == 0) ? 4 + $urandom_range(0, 2) : $urandom_range(0, 3);
            d2 = ($urandom_range(0, 7) == 0) ? 4 + $urandom_range(0, 2) : $urandom_range(0, 3);
            w   = a[31:2];
            sh  = 8 * (3 - int'(a[1:0]));
            cur = ref_get(w);
            elat = 1;
            eerr = 1'b0;
            erd  = 32'h0;
            chk_rd = 1'b1;
            if ((k > 3'd4) || (((k == 3'd0) || (k == 3'd1)) && (a[1:0] != 2'b00))) begin
                eerr   = 1'b1;
                chk_rd = 1'b0;
            end else begin
                if (k != 3'd1) begin
                    dly_q.push_back(d1);
                    if (d1 >= int'(TO)) begin
                        elat += int'(TO);
                        eerr  = 1'b1;
                    end else begin
                        elat += d1 + 1;
                        exp_q.push_back({1'b0, w, 2'b00, 32'h0});
                    end
                end
                if (!eerr && ((k == 3'd1) || (k == 3'd4))) begin
                    nw = (k == 3'd1) ? wd : ((cur & ~(32'hFF << sh)) | ({24'h0, wd[7:0]} << sh));
                    dly_q.push_back(d2);
                    if (d2 >= int'(TO)) begin
                        elat += int'(TO);
                        eerr  = 1'b1;
                    end else begin
                        elat += d2 + 1;
                        exp_q.push_back({1'b1, w, 2'b00, nw});
                        ref_mem[w] = nw;
                    end
                end
                if (!eerr && (k <= 3'd3) && (k != 3'd1)) begin
                    byt = 8'(cur >> sh);
                    if (k == 3'd0)      erd = cur;
                    else if (k == 3'd3) erd = {24'h0, byt};
                    else                erd = (byt >= 8'd128) ? 32'hFFFF_FF00 + {24'h0, byt} : {24'h0, byt};
                end
            end
            run_op(k, a, wd, 1'b0, rd, e, lat);
            chk($sformatf("rnd%0d_err", i), 32'(e), 32'(eerr));
            if (chk_rd) chk($sformatf("rnd%0d_rdata", i), rd, erd);
            chk($sformatf("rnd%0d_latency", i), lat, elat);
            check_log($sformatf("rnd%0d", i));
            if (dly_q.size() != 0) begin
                chk($sformatf("rnd%0d_unused_delays", i), dly_q.size(), 32'd0);
                dly_q.delete();
            end
        end

        for (int j = 0; j < 16; j++) begin
            w = 30'h2000 + 30'(j);
            chk($sformatf("final_mem_word%0d", j), mem_get(w), ref_get(w));
        end
        chk("bus_stability", stab_bad, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
